rvee_wb: RTL

// Writeback stage and the producing end of the register-file write port. Accepts

---
 rtl/rvee_wb_if.sv | 49 ++++
 rtl/rvee_wb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rvee_wb_if.sv
// Bundle of MEM-side retire handshake, data-bus load response and the
// register-file write port seen by the writeback stage.
interface rvee_wb_if #(
  parameter int XLEN   = 32,
  parameter int N_REGS = 32,
  parameter int RIDX   = $clog2(N_REGS)
);

  // Retiring instruction from MEM
  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [RIDX-1:0] mem_rd;
  logic            mem_is_load;
  logic [1:0]      mem_load_size;
  logic            mem_load_unsigned;
  logic [1:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_data;

  // Load response from the data bus
  logic            dbus_rvalid;
  logic [XLEN-1:0] dbus_rdata;
  logic            dbus_rerr;

  // Register-file write port and hazard / fault reporting
  logic            wb_we;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            pend_valid;
  logic [RIDX-1:0] pend_rd;
  logic            load_fault;

  // Producer side: MEM stage plus data bus, consuming the stage outputs
  modport master (
    output mem_valid, mem_we, mem_rd, mem_is_load, mem_load_size,
           mem_load_unsigned, mem_addr_lo, mem_data,
           dbus_rvalid, dbus_rdata, dbus_rerr,
    input  mem_ready, wb_we, wb_rd, wb_data, pend_valid, pend_rd, load_fault
  );

  // The writeback stage itself
  modport slave (
    input  mem_valid, mem_we, mem_rd, mem_is_load, mem_load_size,
           mem_load_unsigned, mem_addr_lo, mem_data,
           dbus_rvalid, dbus_rdata, dbus_rerr,
    output mem_ready, wb_we, wb_rd, wb_data, pend_valid, pend_rd, load_fault
  );

endinterface

// File: rtl/rvee_wb.sv
// Writeback stage: retires ALU results directly, waits for and formats load
// responses, and drives the registered register-file write port. The
// destination of an outstanding load is exported so decode can stall
// dependent reads that forwarding cannot cover.
module rvee_wb #(
  parameter int XLEN   = 32,
  parameter int N_REGS = 32,
  parameter int RIDX   = $clog2(N_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  rvee_wb_if.slave      bus
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t          state;

  // Load attributes captured at accept, used when the response arrives
  logic [RIDX-1:0] rd_l;
  logic            we_l;
  logic [1:0]      size_l;
  logic            uns_l;
  logic [1:0]      off_l;

  // Registered outputs
  logic            wb_we_q;
  logic [RIDX-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic [RIDX-1:0] pend_rd_q;
  logic            load_fault_q;

  logic            accept;
  logic [XLEN-1:0] load_value;

  // Select the addressed byte/half of the response word and extend it.
  // Size 3 is reserved and behaves as a full word.
  function automatic logic [XLEN-1:0] load_extend(
    input logic [XLEN-1:0] word,
    input logic [1:0]      size,
    input logic            uns,
    input logic [1:0]      off
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = {{(XLEN-8){b[7] & ~uns}}, b};
      2'd1:    r = {{(XLEN-16){h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign bus.mem_ready = (state == IDLE) && !rst;
  assign accept        = bus.mem_valid && (state == IDLE);
  assign load_value    = load_extend(bus.dbus_rdata, size_l, uns_l, off_l);

  // Writeback FSM: accept from MEM, wait for the load response, drive the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_l         <= '0;
      we_l         <= 1'b0;
      size_l       <= 2'd0;
      uns_l        <= 1'b0;
      off_l        <= 2'd0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      pend_rd_q    <= '0;
      load_fault_q <= 1'b0;
    end else begin
      wb_we_q      <= 1'b0;
      load_fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.mem_is_load) begin
              rd_l      <= bus.mem_rd;
              we_l      <= bus.mem_we;
              size_l    <= bus.mem_load_size;
              uns_l     <= bus.mem_load_unsigned;
              off_l     <= bus.mem_addr_lo;
              pend_rd_q <= bus.mem_rd;
              state     <= WAIT_LOAD;
            end else if (bus.mem_we && (bus.mem_rd != '0)) begin
              wb_we_q   <= 1'b1;
              wb_rd_q   <= bus.mem_rd;
              wb_data_q <= bus.mem_data;
            end
          end
        end
        WAIT_LOAD: begin
          if (bus.dbus_rvalid) begin
            state     <= IDLE;
            pend_rd_q <= '0;
            if (bus.dbus_rerr) begin
              load_fault_q <= 1'b1;
            end else if (we_l && (rd_l != '0)) begin
              wb_we_q   <= 1'b1;
              wb_rd_q   <= rd_l;
              wb_data_q <= load_value;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_we      = wb_we_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.pend_valid = (state == WAIT_LOAD);
  assign bus.pend_rd    = pend_rd_q;
  assign bus.load_fault = load_fault_q;

endmodule
